// File: rtl/rect_painter_if.sv
// rect_painter_if: rectangle command queue handshake plus VGA memory write port.
interface rect_painter_if #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_BITS = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [X_BITS-1:0]     cmd_x0;
  logic [Y_BITS-1:0]     cmd_y0;
  logic [X_BITS-1:0]     cmd_x1;
  logic [Y_BITS-1:0]     cmd_y1;
  logic [COLOR_BITS-1:0] cmd_color;
  logic                  cmd_mode;
  logic                  busy;
  logic                  done;
  logic [ADDR_BITS-1:0]  address;
  logic [COLOR_BITS-1:0] color;
  logic                  print_enable;
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_mode,
    input  cmd_ready, busy, done, address, color, print_enable
  );
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_mode,
    output cmd_ready, busy, done, address, color, print_enable
  );
endinterface

// File: rtl/rect_painter.sv
// rect_painter: queued rectangle fill/outline engine driving the VGA memory write port.
module rect_painter #(
  parameter int SCR_WIDTH  = 160,
  parameter int SCR_HEIGHT = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_BITS = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_HOLD    = 1
) (
  input logic           Clck,
  input logic           Reset,
  rect_painter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 2 * X_BITS + 2 * Y_BITS + COLOR_BITS + 1;
  localparam int HW = WR_HOLD > 1 ? $clog2(WR_HOLD) : 1;
  localparam logic [X_BITS-1:0] W_X = X_BITS'(SCR_WIDTH);
  localparam logic [Y_BITS-1:0] H_Y = Y_BITS'(SCR_HEIGHT);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, NEXT} state_t;
  state_t                state_q;
  logic [CW-1:0]         fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [PW:0]           cnt_q;
  logic [X_BITS-1:0]     x0_q, x1_q, x_q, x1c, x_d;
  logic [Y_BITS-1:0]     y0_q, y1_q, y_q, y1c, y_d;
  logic [COLOR_BITS-1:0] col_q, color_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [HW-1:0]         hold_q;
  logic                  mode_q, pe_q, done_q;
  logic                  push, pop, degen, row_end, last, edge_row;
  function automatic logic [ADDR_BITS-1:0] addr_of(input logic [Y_BITS-1:0] y, input logic [X_BITS-1:0] x);
    return ADDR_BITS'(y) * ADDR_BITS'(SCR_WIDTH) + ADDR_BITS'(x);
  endfunction
  assign bus.cmd_ready    = cnt_q != (PW+1)'(FIFO_DEPTH);
  assign bus.busy         = state_q != IDLE || cnt_q != '0;
  assign bus.done         = done_q;
  assign bus.address      = addr_q;
  assign bus.color        = color_q;
  assign bus.print_enable = pe_q;
  always_comb begin
    push     = bus.cmd_valid && bus.cmd_ready;
    pop      = state_q == IDLE && cnt_q != '0;
    x1c      = x1_q > W_X ? W_X : x1_q;
    y1c      = y1_q > H_Y ? H_Y : y1_q;
    degen    = x1c <= x0_q || y1c <= y0_q;
    row_end  = x_q == x1_q - 1'b1;
    last     = row_end && y_q == y1_q - 1'b1;
    edge_row = y_q == y0_q || y_q == y1_q - 1'b1;
    // outline interior rows jump straight from the left edge to the right edge
    x_d      = row_end ? x0_q : (mode_q && !edge_row && x_q == x0_q) ? x1_q - 1'b1 : x_q + 1'b1;
    y_d      = row_end ? y_q + 1'b1 : y_q;
  end
  always_ff @(posedge Clck) begin
    if (push) fifo_q[wr_q] <= {bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1, bus.cmd_color, bus.cmd_mode};
    if (!Reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      color_q <= '0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      case (state_q)
        IDLE: if (pop) begin
          {x0_q, y0_q, x1_q, y1_q, col_q, mode_q} <= fifo_q[rd_q];
          state_q <= LOAD;
        end
        LOAD: if (degen) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          x1_q    <= x1c;
          y1_q    <= y1c;
          x_q     <= x0_q;
          y_q     <= y0_q;
          addr_q  <= addr_of(y0_q, x0_q);
          color_q <= col_q;
          pe_q    <= 1'b1;
          hold_q  <= '0;
          state_q <= WRITE;
        end
        WRITE: if (hold_q == HW'(WR_HOLD - 1)) begin
          pe_q    <= 1'b0;
          state_q <= NEXT;
        end else hold_q <= hold_q + 1'b1;
        NEXT: if (last) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          x_q     <= x_d;
          y_q     <= y_d;
          addr_q  <= addr_of(y_d, x_d);
          pe_q    <= 1'b1;
          hold_q  <= '0;
          state_q <= WRITE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
